// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write-channel arbiter in front of a single memory-controller write port.
// Round-robin on simultaneous requests; the grant is held from AW through the B response.
`ifndef ROW_BITS
`define ROW_BITS 14
`endif
`ifndef COL_BITS
`define COL_BITS 10
`endif
`ifndef BA_BITS
`define BA_BITS 3
`endif
`ifndef DQ_BITS
`define DQ_BITS 16
`endif

module axi_wr_arbiter #(
   parameter int ADDR_WIDTH = `ROW_BITS + `COL_BITS + `BA_BITS,
   parameter int DATA_WIDTH = `DQ_BITS * 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              m_awvalid,
   output logic [1:0]              m_awready,
   input  logic [2*ADDR_WIDTH-1:0] m_awaddr,
   input  logic [15:0]             m_awlen,
   input  logic [1:0]              m_wvalid,
   output logic [1:0]              m_wready,
   input  logic [1:0]              m_wlast,
   input  logic [2*DATA_WIDTH-1:0] m_wdata,
   output logic [1:0]              m_bvalid,
   input  logic [1:0]              m_bready,
   output logic                    s_awvalid,
   input  logic                    s_awready,
   output logic [ADDR_WIDTH-1:0]   s_awaddr,
   output logic [7:0]              s_awlen,
   output logic                    s_wvalid,
   input  logic                    s_wready,
   output logic                    s_wlast,
   output logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic                    s_bvalid,
   output logic                    s_bready,
   output logic                    grant,
   output logic                    busy,
   output logic                    len_err,
   output logic [1:0]              dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // Valid never waits on ready; only the granted master sees ready/valid from the slave.
   typedef enum logic [1:0] {IDLE = 2'd0, AW = 2'd1, W = 2'd2, B = 2'd3} state_t;

   state_t     state;
   logic       last_grant;
   logic [7:0] beat_cnt;
   logic [7:0] len_lat;
   logic       aw_hs, w_hs, b_hs;

   assign busy      = (state != IDLE);
   assign dbg_state = state;

   // Payload buses follow the registered grant; only the valid/ready strobes are state-gated.
   assign s_awaddr = grant ? m_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_awaddr[ADDR_WIDTH-1:0];
   assign s_awlen  = grant ? m_awlen[15:8] : m_awlen[7:0];
   assign s_wdata  = grant ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];

   always_comb begin
      m_awready = 2'b00;
      m_wready  = 2'b00;
      m_bvalid  = 2'b00;
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      s_wlast   = 1'b0;
      s_bready  = 1'b0;
      case (state)
         AW: begin
            s_awvalid        = m_awvalid[grant];
            m_awready[grant] = s_awready;
         end
         W: begin
            s_wvalid        = m_wvalid[grant];
            s_wlast         = m_wlast[grant];
            m_wready[grant] = s_wready;
         end
         B: begin
            m_bvalid[grant] = s_bvalid;
            s_bready        = m_bready[grant];
         end
         default: ;
      endcase
   end

   assign aw_hs = s_awvalid & s_awready;
   assign w_hs  = s_wvalid & s_wready;
   assign b_hs  = s_bvalid & s_bready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         beat_cnt   <= 8'd0;
         len_lat    <= 8'd0;
         len_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|m_awvalid) begin
               // On a tie the master that was not served last wins.
               grant <= (&m_awvalid) ? ~last_grant : m_awvalid[1];
               state <= AW;
            end
            AW: if (aw_hs) begin
               len_lat  <= s_awlen;
               beat_cnt <= 8'd0;
               state    <= W;
            end
            W: if (w_hs) begin
               beat_cnt <= beat_cnt + 8'd1;
               if (s_wlast) begin
                  // beat_cnt still holds the index of this last beat, which must equal awlen.
                  if (beat_cnt != len_lat) len_err <= 1'b1;
                  state <= B;
               end
            end
            B: if (b_hs) begin
               last_grant <= grant;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: arbitration order, beat steering, length errors and
// mid-burst reset, with a slave-side scoreboard on the W channel.
module tb_axi_wr_arbiter;
   localparam int AW_W = 16;
   localparam int DW   = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
   logic [2*AW_W-1:0] m_awaddr;
   logic [15:0]       m_awlen;
   logic [2*DW-1:0]   m_wdata;
   logic              s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
   logic [AW_W-1:0]   s_awaddr;
   logic [7:0]        s_awlen;
   logic [DW-1:0]     s_wdata;
   logic              grant, busy, len_err;
   logic [1:0]        dbg_state;

   axi_wr_arbiter #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata),
      .m_bvalid(m_bvalid), .m_bready(m_bready),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .grant(grant), .busy(busy), .len_err(len_err), .dbg_state(dbg_state)
   );

   int            n_chk   = 0;
   int            n_pass  = 0;
   int            tag_cnt = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mon_e;
   logic [AW_W-1:0] aw_addr[2];
   logic [7:0]      aw_len[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Slave-side scoreboard: every accepted W beat must be the next expected word.
   always @(posedge clk) begin
      if (!rst && s_wvalid && s_wready) begin
         n_chk++;
         assert (exp_q.size() > 0)
         else $error("FAIL wdata_extra: observed %0h expected none", s_wdata);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            assert (s_wdata === mon_e) n_pass++;
            else $error("FAIL wdata: observed %0h expected %0h", s_wdata, mon_e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int m, input logic [AW_W-1:0] addr, input logic [7:0] len);
      aw_addr[m] = addr;
      aw_len[m]  = len;
      m_awaddr[m*AW_W +: AW_W] = addr;
      m_awlen[m*8 +: 8]        = len;
      m_awvalid[m]             = 1'b1;
   endtask

   // Entered with the DUT in AW for master m; leaves it back in IDLE after the B handshake.
   task automatic run_burst(input int m, input int nbeats, input bit toggle, input bit keep_aw);
      int            beat;
      int            cyc;
      logic [DW-1:0] d;
      logic          wr;
      logic [1:0]    onehot;
      onehot = (m == 1) ? 2'b10 : 2'b01;
      check("aw_state", 32'(dbg_state), 32'd1);
      check("aw_grant", 32'(grant), 32'(m));
      check("aw_addr", 32'(s_awaddr), 32'(aw_addr[m]));
      check("aw_len", 32'(s_awlen), 32'(aw_len[m]));
      check("aw_ready", 32'(m_awready), 32'(onehot));
      tick();
      if (!keep_aw) m_awvalid[m] = 1'b0;
      beat = 0;
      cyc  = 0;
      while (beat < nbeats && cyc < 40) begin
         d = {8'hD0, 8'(tag_cnt), 8'(m), 8'(beat)};
         m_wvalid[m] = 1'b1;
         m_wdata[m*DW +: DW] = d;
         m_wlast[m] = (beat == nbeats - 1);
         wr = toggle ? (cyc % 2 == 0) : 1'b1;
         s_wready = wr;
         #1;
         check("w_state", 32'(dbg_state), 32'd2);
         check("w_ready", 32'(m_wready), wr ? 32'(onehot) : 32'd0);
         if (wr) begin
            exp_q.push_back(d);
            beat++;
         end
         tick();
         cyc++;
      end
      check("w_budget", 32'(beat), 32'(nbeats));
      m_wvalid[m] = 1'b0;
      m_wlast[m]  = 1'b0;
      s_wready    = 1'b1;
      #1;
      check("b_state", 32'(dbg_state), 32'd3);
      check("b_valid", 32'(m_bvalid), 32'(onehot));
      m_bready[m] = 1'b1;
      #1;
      check("b_ready", 32'(s_bready), 32'd1);
      tick();
      m_bready[m] = 1'b0;
      check("b_done", 32'(dbg_state), 32'd0);
      check("wdata_drained", 32'(exp_q.size()), 32'd0);
      tag_cnt++;
   endtask

   initial begin
      m_awvalid = 2'b00; m_awaddr = '0; m_awlen = '0;
      m_wvalid = 2'b00; m_wlast = 2'b00; m_wdata = '0; m_bready = 2'b00;
      s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
      rst = 1'b1;
      tick();
      m_awvalid = 2'b11;
      tick();
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_len_err", 32'(len_err), 32'd0);
      check("rst_s_valids", {29'd0, s_awvalid, s_wvalid, s_bready}, 32'd0);
      check("rst_m_outs", {26'd0, m_awready, m_wready, m_bvalid}, 32'd0);
      m_awvalid = 2'b00;
      rst = 1'b0;

      // Tie after reset: master 0 first, master 1 parks its W data meanwhile.
      set_req(0, 16'h1000, 8'd3);
      set_req(1, 16'h2000, 8'd3);
      m_wvalid[1] = 1'b1;
      m_wdata[DW +: DW] = 32'hBAD0_0001;
      #1;
      check("idle_awready", 32'(m_awready), 32'd0);
      check("idle_s_awvalid", 32'(s_awvalid), 32'd0);
      tick();
      run_burst(0, 4, 1'b0, 1'b0);
      check("rr_idle_busy", 32'(busy), 32'd0);
      tick();
      run_burst(1, 4, 1'b0, 1'b0);
      check("tie_len_err", 32'(len_err), 32'd0);

      // Master 1 alone and requesting continuously: one IDLE cycle between bursts.
      set_req(1, 16'h3000, 8'd1);
      tick();
      run_burst(1, 2, 1'b0, 1'b1);
      check("gap_idle", 32'(busy), 32'd0);
      tick();
      check("b2b_busy", 32'(busy), 32'd1);
      run_burst(1, 2, 1'b0, 1'b0);

      // Slave W backpressure alternating 1,0,1,0.
      set_req(0, 16'h4000, 8'd3);
      tick();
      run_burst(0, 4, 1'b1, 1'b0);
      check("toggle_len_err", 32'(len_err), 32'd0);

      // Early wlast on beat 2 of a 4-beat burst.
      set_req(0, 16'h5000, 8'd3);
      tick();
      run_burst(0, 2, 1'b0, 1'b0);
      check("short_len_err", 32'(len_err), 32'd1);
      tick();
      check("sticky_len_err", 32'(len_err), 32'd1);
      set_req(1, 16'h6000, 8'd3);
      tick();
      run_burst(1, 4, 1'b0, 1'b0);
      check("after_len_err", 32'(len_err), 32'd1);

      // Make master 0 the last served, then reset in the middle of a master-1 burst.
      set_req(0, 16'h7000, 8'd0);
      tick();
      run_burst(0, 1, 1'b0, 1'b0);
      set_req(1, 16'h8000, 8'd3);
      tick();
      check("pre_rst_grant", 32'(grant), 32'd1);
      tick();
      m_awvalid[1] = 1'b0;
      for (int b = 0; b < 2; b++) begin
         m_wvalid[1] = 1'b1;
         m_wdata[DW +: DW] = {8'hE0, 16'h0, 8'(b)};
         exp_q.push_back({8'hE0, 16'h0, 8'(b)});
         tick();
      end
      m_awvalid = 2'b11;
      #1;
      check("pre_rst_wvalid", 32'(s_wvalid), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_wvalid", 32'(s_wvalid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_wready", 32'(m_wready), 32'd0);
      check("midrst_grant", 32'(grant), 32'd0);
      check("midrst_len_err", 32'(len_err), 32'd0);
      tick();
      rst = 1'b0;
      m_wvalid = 2'b00;
      #1;
      check("post_rst_idle", 32'(dbg_state), 32'd0);
      tick();
      check("post_rst_grant", 32'(grant), 32'd0);
      run_burst(0, 1, 1'b0, 1'b0);
      m_awvalid = 2'b00;
      tick();
      check("end_queue", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #50000;
      n_chk++;
      $error("FAIL timeout: observed no finish expected finish before 50000");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
